seg_scan_driver: RTL and testbench

Time-multiplexed N-digit 7-segment display driver for the digital clock. It scans one digit per slot and decodes BCD, with optional hex, onto shared segment lines. Per digit it supports blanking, blinking for the time-set cursor, decimal point and leading-zero suppression. Inputs are snapshotted once per frame so a display never tears mid-scan. It sits between the time-keeping counters and the board's segment/digit pins.

---
 rtl/seg_scan_driver.sv | 147 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: BCD/hex decode, blank, blink, dp and leading-zero suppression.
// Latency: outputs update on the prescaler terminal-count edge; digit 0 first appears SCAN_DIV cycles after reset.
// Backpressure: none; free-running scan, inputs snapshotted once per frame.
module seg_scan_driver #(
    parameter int N_DIGITS     = 6,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [4*N_DIGITS-1:0] i_num,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic [N_DIGITS-1:0]   i_blank,
    input  logic [N_DIGITS-1:0]   i_blink,
    input  logic                  i_lzs,
    input  logic                  i_hex,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic [N_DIGITS-1:0]   o_dig,
    output logic                  o_frame
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [4*N_DIGITS-1:0] sh_num;
    logic [N_DIGITS-1:0]   sh_dp, sh_blank, sh_blink;
    logic                  sh_lzs, sh_hex;
    logic [FW-1:0]         frame_cnt;
    logic                  blink_phase;

    logic                  tc, last, wrap, frame_done, cnt_end, phase_n;
    logic [IW-1:0]         idx_n;
    logic [4*N_DIGITS-1:0] n_num;
    logic [N_DIGITS-1:0]   n_dp, n_blank, n_blink;
    logic                  n_lzs, n_hex;
    logic [3:0]            cur_val;
    logic                  lz_hit, dark;
    logic [6:0]            seg_n;
    logic                  dp_n;
    logic [N_DIGITS-1:0]   dig_n;

    function automatic logic [6:0] decode(input logic [3:0] v, input logic hex);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110010;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            4'd10:   s = hex ? 7'b1110111 : 7'b0000001;
            4'd11:   s = hex ? 7'b0011111 : 7'b0000001;
            4'd12:   s = hex ? 7'b1001110 : 7'b0000001;
            4'd13:   s = hex ? 7'b0111101 : 7'b0000001;
            4'd14:   s = hex ? 7'b1001111 : 7'b0000001;
            default: s = hex ? 7'b1000111 : 7'b0000001;
        endcase
        return s;
    endfunction

    always_comb begin
        tc    = (presc == PW'(SCAN_DIV - 1));
        last  = (idx == IW'(N_DIGITS - 1));
        wrap  = tc && last;
        idx_n = last ? '0 : idx + IW'(1);

        n_num   = wrap ? i_num   : sh_num;
        n_dp    = wrap ? i_dp    : sh_dp;
        n_blank = wrap ? i_blank : sh_blank;
        n_blink = wrap ? i_blink : sh_blink;
        n_lzs   = wrap ? i_lzs   : sh_lzs;
        n_hex   = wrap ? i_hex   : sh_hex;

        // The very first wrap after reset starts frame 0 rather than completing one.
        frame_done = wrap && (o_dig != '0);
        cnt_end    = (frame_cnt == FW'(BLINK_FRAMES - 1));
        phase_n    = (frame_done && cnt_end) ? ~blink_phase : blink_phase;

        cur_val = n_num[{idx_n, 2'b00} +: 4];

        lz_hit = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if ((IW'(k) >= idx_n) && (n_num[4*k +: 4] != 4'd0)) lz_hit = 1'b0;
        end

        dark = n_blank[idx_n]
             | (n_blink[idx_n] & phase_n)
             | (n_lzs & (idx_n != '0) & lz_hit);

        seg_n = dark ? 7'b0000000 : decode(cur_val, n_hex);
        dp_n  = dark ? 1'b0 : n_dp[idx_n];

        dig_n = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            dig_n[k] = (IW'(k) == idx_n);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc       <= '0;
            idx         <= IW'(N_DIGITS - 1);
            sh_num      <= '0;
            sh_dp       <= '0;
            sh_blank    <= '0;
            sh_blink    <= '0;
            sh_lzs      <= 1'b0;
            sh_hex      <= 1'b0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            o_seg       <= '0;
            o_dp        <= 1'b0;
            o_dig       <= '0;
            o_frame     <= 1'b0;
        end else begin
            presc   <= tc ? '0 : presc + PW'(1);
            o_frame <= wrap;
            if (tc) begin
                idx   <= idx_n;
                o_seg <= seg_n;
                o_dp  <= dp_n;
                o_dig <= dig_n;
            end
            if (wrap) begin
                sh_num   <= i_num;
                sh_dp    <= i_dp;
                sh_blank <= i_blank;
                sh_blink <= i_blink;
                sh_lzs   <= i_lzs;
                sh_hex   <= i_hex;
            end
            if (frame_done) begin
                frame_cnt   <= cnt_end ? '0 : frame_cnt + FW'(1);
                blink_phase <= phase_n;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (4-digit and 1-digit builds, SCAN_DIV=4, BLINK_FRAMES=2).
module tb_seg_scan_driver;

    localparam int SDIV = 4;

    localparam logic [6:0] SEG_0 = 7'b1111110, SEG_1 = 7'b0110000, SEG_2 = 7'b1101101,
                           SEG_3 = 7'b1111001, SEG_4 = 7'b0110011, SEG_5 = 7'b1011011,
                           SEG_6 = 7'b1011111, SEG_7 = 7'b1110010, SEG_8 = 7'b1111111,
                           SEG_9 = 7'b1111011, SEG_A = 7'b1110111, SEG_B = 7'b0011111,
                           SEG_C = 7'b1001110, SEG_D = 7'b0111101, SEG_E = 7'b1001111,
                           SEG_F = 7'b1000111, DASH  = 7'b0000001, DARK  = 7'b0000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [15:0] num = '0;
    logic [3:0]  dp = '0, blank = '0, blink = '0;
    logic        lzs = 1'b0, hex = 1'b0;
    logic [6:0]  seg;
    logic        odp, frame;
    logic [3:0]  dig;

    logic        rst1 = 1'b1;
    logic [3:0]  num1 = '0;
    logic        dp1 = 1'b0, blank1 = 1'b0, blink1 = 1'b0, lzs1 = 1'b0, hex1 = 1'b0;
    logic [6:0]  seg1;
    logic        odp1, frame1;
    logic [0:0]  dig1;

    seg_scan_driver #(.N_DIGITS(4), .SCAN_DIV(SDIV), .BLINK_FRAMES(2)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_num(num), .i_dp(dp), .i_blank(blank),
        .i_blink(blink), .i_lzs(lzs), .i_hex(hex),
        .o_seg(seg), .o_dp(odp), .o_dig(dig), .o_frame(frame)
    );

    seg_scan_driver #(.N_DIGITS(1), .SCAN_DIV(SDIV), .BLINK_FRAMES(2)) u_dut1 (
        .i_clk(clk), .i_rst(rst1), .i_num(num1), .i_dp(dp1), .i_blank(blank1),
        .i_blink(blink1), .i_lzs(lzs1), .i_hex(hex1),
        .o_seg(seg1), .o_dp(odp1), .o_dig(dig1), .o_frame(frame1)
    );

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] d, input logic [6:0] s, input logic p);
        exp_t e;
        e.dig = d;
        e.seg = s;
        e.dp  = p;
        q.push_back(e);
    endtask

    // Monitor: a new digit slot is recognised by a change of o_dig.
    initial begin
        logic [3:0] last_dig;
        int         hold;
        exp_t       e;
        last_dig = '0;
        hold     = 0;
        forever begin
            @(negedge clk);
            if (dig !== last_dig) begin
                if (dig != '0 && q.size() > 0) begin
                    e = q.pop_front();
                    chk("dig", 32'(dig), 32'(e.dig));
                    chk("seg", 32'(seg), 32'(e.seg));
                    chk("dp", 32'(odp), 32'(e.dp));
                    chk("frame", 32'(frame), 32'(e.dig == 4'b0001));
                end
                if (dig != '0 && last_dig != '0) chk("hold", 32'(hold), 32'(SDIV));
                hold     = 1;
                last_dig = dig;
            end else begin
                hold++;
                chk("frame_stray", 32'(frame), 32'd0);
            end
        end
    end

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_seg", 32'(seg), 32'd0);
        chk("rst_dp", 32'(odp), 32'd0);
        chk("rst_dig", 32'(dig), 32'd0);
        chk("rst_frame", 32'(frame), 32'd0);
        rst = 1'b0;
    endtask

    task automatic startup();
        repeat (SDIV - 1) begin
            @(posedge clk); #1;
            chk("start_dig", 32'(dig), 32'd0);
            chk("start_seg", 32'(seg), 32'd0);
        end
        @(posedge clk); #1;
        chk("first_dig", 32'(dig), 32'd1);
        chk("first_frame", 32'(frame), 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic set_in(input logic [15:0] n, input logic [3:0] d, input logic [3:0] bk,
                          input logic [3:0] bl, input logic z, input logic h);
        num = n; dp = d; blank = bk; blink = bl; lzs = z; hex = h;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;

        // Scan order, then a mid-frame input change that must wait for the next frame.
        set_in(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        reset_dut();
        push(4'b0001, SEG_4, 1'b0); push(4'b0010, SEG_3, 1'b0);
        push(4'b0100, SEG_2, 1'b0); push(4'b1000, SEG_1, 1'b0);
        for (int i = 0; i < 4; i++) push(4'(1 << i), SEG_9, 1'b0);
        startup();
        repeat (2) @(posedge clk);
        #1;
        num = 16'h9999;
        wait_drain(100);

        // Leading-zero suppression and hex/dash decoding.
        set_in(16'h00A0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        reset_dut();
        push(4'b0001, SEG_0, 1'b0); push(4'b0010, SEG_A, 1'b0);
        push(4'b0100, DARK, 1'b0);  push(4'b1000, DARK, 1'b0);
        startup();
        wait_drain(100);

        set_in(16'h00A0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        reset_dut();
        push(4'b0001, SEG_0, 1'b0); push(4'b0010, DASH, 1'b0);
        push(4'b0100, DARK, 1'b0);  push(4'b1000, DARK, 1'b0);
        startup();
        wait_drain(100);

        set_in(16'h0102, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        reset_dut();
        push(4'b0001, SEG_2, 1'b0); push(4'b0010, SEG_0, 1'b0);
        push(4'b0100, SEG_1, 1'b0); push(4'b1000, DARK, 1'b0);
        startup();
        wait_drain(100);

        set_in(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        reset_dut();
        push(4'b0001, SEG_0, 1'b0); push(4'b0010, DARK, 1'b0);
        push(4'b0100, DARK, 1'b0);  push(4'b1000, DARK, 1'b0);
        startup();
        wait_drain(100);

        set_in(16'hFEDC, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        reset_dut();
        push(4'b0001, SEG_C, 1'b0); push(4'b0010, SEG_D, 1'b0);
        push(4'b0100, SEG_E, 1'b0); push(4'b1000, SEG_F, 1'b0);
        startup();
        wait_drain(100);

        set_in(16'h8B76, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        reset_dut();
        push(4'b0001, SEG_6, 1'b0); push(4'b0010, SEG_7, 1'b0);
        push(4'b0100, SEG_B, 1'b0); push(4'b1000, SEG_8, 1'b0);
        startup();
        wait_drain(100);

        // Blink on digit 0, blank on digit 3 (its dp request is also suppressed), dp on digit 2.
        set_in(16'h5555, 4'b1100, 4'b1000, 4'b0001, 1'b0, 1'b0);
        reset_dut();
        for (int f = 0; f < 5; f++) begin
            push(4'b0001, (f == 2 || f == 3) ? DARK : SEG_5, 1'b0);
            push(4'b0010, SEG_5, 1'b0);
            push(4'b0100, SEG_5, 1'b1);
            push(4'b1000, DARK, 1'b0);
        end
        startup();
        wait_drain(200);

        // Reset during digit 2 of a dark blink frame: blink phase must return to visible.
        set_in(16'h1234, 4'h0, 4'h0, 4'b0001, 1'b0, 1'b0);
        reset_dut();
        for (int f = 0; f < 2; f++) begin
            push(4'b0001, SEG_4, 1'b0); push(4'b0010, SEG_3, 1'b0);
            push(4'b0100, SEG_2, 1'b0); push(4'b1000, SEG_1, 1'b0);
        end
        push(4'b0001, DARK, 1'b0); push(4'b0010, SEG_3, 1'b0); push(4'b0100, SEG_2, 1'b0);
        startup();
        wait_drain(200);
        reset_dut();
        push(4'b0001, SEG_4, 1'b0); push(4'b0010, SEG_3, 1'b0);
        push(4'b0100, SEG_2, 1'b0); push(4'b1000, SEG_1, 1'b0);
        push(4'b0001, SEG_4, 1'b0);
        startup();
        wait_drain(100);

        // Single-digit build: every TC is a frame wrap and reloads the snapshot.
        num1 = 4'd7;
        rst1 = 1'b1;
        @(posedge clk); #1;
        chk("n1_rst_dig", 32'(dig1), 32'd0);
        chk("n1_rst_frame", 32'(frame1), 32'd0);
        rst1 = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            chk("n1_dig", 32'(dig1), (c >= 4) ? 32'd1 : 32'd0);
            chk("n1_frame", 32'(frame1), (c % 4 == 0) ? 32'd1 : 32'd0);
            chk("n1_seg", 32'(seg1), (c < 4) ? 32'(DARK) : (c < 12) ? 32'(SEG_7) : 32'(SEG_3));
            if (c == 9) num1 = 4'd3;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
